// File: rtl/bnn_pkg.sv
// Shared BNN definitions: collector FSM states and sizing helpers
// used by both the convolver front end and the result collector.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collect_state_t;

  function automatic int pop_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  function automatic int thresh_def(input int taps);
    return (taps + 1) / 2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position with column wrap and end-of-frame flag.
module raster_counter
  import bnn_pkg::*;
#(
  parameter int ROWS = 26,
  parameter int COLS = 26,
  parameter int RW   = cnt_w(ROWS),
  parameter int CW   = cnt_w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_MAX);
  assign col_end = (col == COL_MAX);
  assign last    = row_end && col_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bconv_result_collector.sv
// Binarizes the popcount stream against THRESH and assembles the
// OUTPUT_H x OUTPUT_W feature map for the next BNN layer.
module bconv_result_collector
  import bnn_pkg::*;
#(
  parameter int OUTPUT_H = 26,
  parameter int OUTPUT_W = 26,
  parameter int K_H      = 3,
  parameter int K_W      = 3,
  parameter int POP_W    = pop_w(K_H * K_W),
  parameter int THRESH   = thresh_def(K_H * K_W)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pop_valid,
  input  logic [POP_W-1:0]                   pop_data,
  output logic                               pop_ready,
  output logic [OUTPUT_H-1:0][OUTPUT_W-1:0]  layer_o,
  output logic                               busy,
  output logic                               done,
  output logic                               range_err
);

  localparam int RW = cnt_w(OUTPUT_H);
  localparam int CW = cnt_w(OUTPUT_W);

  localparam logic [POP_W-1:0] TH   = POP_W'(THRESH);
  localparam logic [POP_W-1:0] KMAX = POP_W'(K_H * K_W);

  collect_state_t state;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;
  logic          fire;
  logic          launch;

  assign launch    = (state == ST_IDLE) && start;
  assign fire      = (state == ST_COLLECT) && pop_valid;
  assign pop_ready = (state == ST_COLLECT);
  assign busy      = (state == ST_COLLECT);
  assign done      = (state == ST_DONE);

  raster_counter #(
    .ROWS (OUTPUT_H),
    .COLS (OUTPUT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (launch),
    .en   (fire),
    .row  (row),
    .col  (col),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      layer_o   <= '0;
      range_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_COLLECT;
            layer_o   <= '0;
            range_err <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (pop_valid) begin
            // Out-of-range words still get their compare bit written.
            layer_o[row][col] <= (pop_data >= TH);
            if (pop_data > KMAX) range_err <= 1'b1;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bconv_result_collector.md
# bconv_result_collector

Receive-side companion to the binary-convolution front end: accepts the stream of XNOR-popcount results (one per output pixel, raster order) over a valid/ready handshake, binarizes each against a threshold, and assembles the full OUTPUT_H×OUTPUT_W binary feature map. Sits between the convolver's popcount output and the next BNN layer, which reads `layer_o` once `done` pulses.

## Interface
Parameters
- `OUTPUT_H`, 26: output map rows.
- `OUTPUT_W`, 26: output map columns.
- `K_H`, 3: kernel rows.
- `K_W`, 3: kernel columns.
- `POP_W`, `$clog2(K_H*K_W+1)` (4): popcount width.
- `THRESH`, `(K_H*K_W+1)/2` (5): binarization threshold; output bit = 1 iff popcount ≥ THRESH.

Ports
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new frame; sampled in IDLE only.
- `pop_valid`  in  1  popcount word present.
- `pop_data`  in  POP_W  popcount for the current pixel.
- `pop_ready`  out  1  collector accepts a word this cycle.
- `layer_o`  out  [OUTPUT_H-1:0][OUTPUT_W-1:0]  assembled binary map, `layer_o[r][c]`.
- `busy`  out  1  frame in progress (COLLECT).
- `done`  out  1  one-cycle pulse: frame complete, `layer_o` valid.
- `range_err`  out  1  sticky: a popcount > K_H*K_W was accepted this frame.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE: `pop_ready`=0. `start`=1 → COLLECT; same edge clears `layer_o` to 0, row/col counters to 0, `range_err` to 0.
- COLLECT: `pop_ready`=1, `busy`=1. Transfer = `pop_valid && pop_ready` at rising edge. On transfer: `layer_o[row][col] <= (pop_data >= THRESH)`; if `pop_data > K_H*K_W`, set `range_err` (bit still written per compare).
- Counters: `col` wraps OUTPUT_W-1 → 0 with `row` increment; `row` never exceeds OUTPUT_H-1. Widths `$clog2(OUTPUT_W)`, `$clog2(OUTPUT_H)`.
- Transfer at (OUTPUT_H-1, OUTPUT_W-1) → DONE.
- DONE: `done`=1, `busy`=0, `pop_ready`=0, one cycle only → IDLE unconditionally.
- `layer_o` holds until the next accepted `start` or `rst`; `range_err` holds likewise.
- `start` in COLLECT or DONE ignored. `pop_valid` in IDLE/DONE ignored (no write, no count).
- Compare is unsigned, full POP_W width; no saturation.

## Timing
- Reset values: state IDLE, `pop_ready` 0, `busy` 0, `done` 0, `range_err` 0, `layer_o` all 0, counters 0.
- `rst` mid-frame: on that edge everything returns to reset values; partial map discarded; no `done`.
- `pop_ready` is a registered function of state only (no combinational path from `pop_valid`).
- `busy` asserted first cycle after `start` edge; `pop_ready` likewise.
- Written bit visible on `layer_o` the cycle after its transfer.
- Full frame with `pop_valid` held high: `start` edge at cycle 0, transfers cycles 1..OUTPUT_H*OUTPUT_W, `done` high at cycle OUTPUT_H*OUTPUT_W+1, IDLE next; earliest new `start` accepted in that IDLE cycle.
- Stalls (`pop_valid` low) freeze counters; no timeout.

## Structure
- Shared package `bnn_pkg`: FSM state enum `collect_state_t`, helper function for popcount width, default THRESH expression so convolver and collector agree.
- One natural sub-module: `raster_counter` (row/col with wrap and `last` flag), reusable by the window-generator side.
- Map storage and FSM stay in the top module.

## Test plan
- Reset then `start`, stream 676 words alternating 9/0 with `pop_valid` steady → `layer_o[r][c]` = 1 at even raster indices, `done` pulses exactly once at cycle 677, `range_err`=0.
- Threshold edge: all words = 4 → map all 0; rerun with all = 5 → map all 1; previous frame cleared at `start`.
- Random `pop_valid` gaps (≈50% duty) with random data → map matches reference model bit-for-bit; counters never advance on gaps.
- Word value 12 at pixel (3,7) → `range_err` sets and stays 1 through `done`; bit (3,7)=1; next `start` clears it.
- Assert `rst` after 300 transfers → next cycle `busy`=0, `pop_ready`=0, `layer_o`=0, no `done`; fresh frame completes correctly.
- `start` pulsed during COLLECT and `pop_valid` in IDLE/DONE → no restart, no writes, `done` timing unchanged.
